// File: rtl/sync_frame_rx_pkg.sv
// sync_frame_rx_pkg: types, constants and helpers shared by the serial frame
// receiver and its port interface.
//
// The build macro SYNC_FRAME_RX_PARITY_EN selects whether frames carry an
// even-parity bit. That selection is made in sync_frame_rx.sv, not here.
package sync_frame_rx_pkg;

    // Default payload width, in bits per frame.
    localparam int DATA_W_DEFAULT = 8;

    // Receiver FSM states. PARITY is only visited when parity checking is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        ACK    = 2'd3
    } state_e;

    // Even parity holds when the payload bits and the parity bit together
    // contain an even number of ones. Narrower payloads are zero-extended,
    // and zero extension does not change the XOR.
    function automatic logic even_parity_ok(input logic [31:0] data, input logic pbit);
        return (^{data, pbit}) == 1'b0;
    endfunction

endpackage

// File: rtl/sync_frame_rx_if.sv
// sync_frame_rx_if: the serial line (b), the frame acknowledge (a) and the
// valid/ready word port of the frame receiver.
// slave  : receiver side. It samples b and drives the acknowledge and the word port.
// master : producer/consumer side. It drives b, out_ready and clr_ovf.
// Everything is sampled and driven on posedge of the receiver clock.
// The build macro SYNC_FRAME_RX_PARITY_EN has no effect on this interface.
interface sync_frame_rx_if
    import sync_frame_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              b;           // serial line: idle 0, start bit 1
    logic              a;           // one-cycle frame acknowledge
    logic [DATA_W-1:0] out_data;    // received word
    logic              out_valid;   // out_data holds an unconsumed word
    logic              out_ready;   // downstream takes the word when valid && ready
    logic              parity_err;  // one-cycle pulse on a parity failure
    logic              overflow;    // sticky: a word was dropped because one was pending
    logic              clr_ovf;     // synchronous clear of overflow

    modport slave (
        input  b,
        output a,
        output out_data,
        output out_valid,
        input  out_ready,
        output parity_err,
        output overflow,
        input  clr_ovf
    );

    modport master (
        output b,
        input  a,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  parity_err,
        input  overflow,
        output clr_ovf
    );

endinterface

// File: rtl/sync_frame_rx.sv
// sync_frame_rx: synchronous serial frame receiver.
// A frame is a start bit (1), then DATA_W payload bits sent LSB first, then an
// optional even-parity bit. The received word goes out on a valid/ready port,
// and each frame that is received correctly is acknowledged with a one-cycle
// pulse on a.
//
// Build option SYNC_FRAME_RX_PARITY_EN:
//   defined   - the frame carries a parity bit. A bad frame is discarded and
//               parity_err pulses for one cycle.
//   undefined - there is no parity bit. DATA goes straight to ACK, every frame
//               is good, and parity_err is tied to 0.
module sync_frame_rx
    import sync_frame_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_frame_rx_if.slave bus
);

    // The counter holds values 0..DATA_W and never wraps.
    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
        $error("sync_frame_rx: DATA_W must be within 1..32");
    end

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              a_q,         a_d;
    logic              ovf_q,       ovf_d;
`ifdef SYNC_FRAME_RX_PARITY_EN
    logic              perr_q,      perr_d;
`endif

    logic [DATA_W-1:0] shift_in;    // shift register with the current b entering at the MSB
    logic [DATA_W-1:0] frame_word;  // completed payload, valid when frame_done is set
    logic              frame_done;  // a frame completes on this edge
    logic              frame_good;  // the completed frame passed its check
    logic              consume;     // the downstream takes the pending word on this edge
    logic              ovf_set;     // a good word is dropped on this edge

    // Registered state: the FSM, the shifter and the output registers.
    // NOTE: sequential blocks use only non-blocking (<=) assignments. Every
    // register then updates from values that were taken before the edge, and
    // the order of statements cannot create a race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            a_q         <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef SYNC_FRAME_RX_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            ovf_q       <= ovf_d;
`ifdef SYNC_FRAME_RX_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    // Next state: frame sequencing, the output handshake and the sticky overflow.
    // NOTE: every signal assigned in this block gets a default at the top.
    // Without the defaults, a path through the case or if statements that
    // skips an assignment would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        a_d         = 1'b0;
        ovf_d       = ovf_q;
        frame_done  = 1'b0;
        frame_good  = 1'b0;
        frame_word  = shift_q;
        ovf_set     = 1'b0;
`ifdef SYNC_FRAME_RX_PARITY_EN
        perr_d      = 1'b0;
`endif
        // This form works for DATA_W == 1, where a part-select would be empty.
        shift_in = (shift_q >> 1) | (DATA_W'(bus.b) << (DATA_W - 1));
        consume  = out_valid_q && bus.out_ready;

        case (state_q)
            IDLE: begin
                if (bus.b) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end

            DATA: begin
                shift_d = shift_in;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SYNC_FRAME_RX_PARITY_EN
                    state_d    = PARITY;
`else
                    // Without a parity bit, the last payload bit completes the frame.
                    state_d    = ACK;
                    frame_done = 1'b1;
                    frame_good = 1'b1;
                    frame_word = shift_in;
`endif
                end
            end

`ifdef SYNC_FRAME_RX_PARITY_EN
            PARITY: begin
                state_d    = ACK;
                frame_done = 1'b1;
                frame_good = even_parity_ok(32'(shift_q), bus.b);
                frame_word = shift_q;
            end
`endif

            // b is ignored for one cycle. A new start bit is seen from IDLE at the earliest.
            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The pending word leaves when the downstream accepts it.
        if (consume) begin
            out_valid_d = 1'b0;
        end

        // The acknowledge reports correct reception even when the word has to
        // be dropped. A word consumed on the same edge frees the slot for the new word.
        if (frame_done) begin
            a_d = frame_good;
`ifdef SYNC_FRAME_RX_PARITY_EN
            perr_d = !frame_good;
`endif
            if (frame_good) begin
                if (!out_valid_q || consume) begin
                    out_data_d  = frame_word;
                    out_valid_d = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end

        // When a set and a clear arrive on the same edge, the set wins, so the
        // drop is not lost.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    assign bus.a         = a_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = ovf_q;
`ifdef SYNC_FRAME_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
